// File: rtl/rlc_game_system_ledout_pio.sv
// rlc_game_system_ledout_pio: Avalon-MM LED output PIO with set/clear and per-bit blink
module rlc_game_system_ledout_pio #(
    parameter int          WIDTH        = 10,
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter int          CNT_W        = 26,
    parameter logic [31:0] PERIOD_RESET = 32'd25000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);
    logic             wr;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] blink_en;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] cnt;
    logic             phase;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign wr          = chipselect & ~write_n;
    assign unused_bits = ^writedata;

    // bus-writable registers: DATA, BLINK, PERIOD and the atomic set/clear aliases
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data     <= RESET_VALUE[WIDTH-1:0];
            blink_en <= '0;
            period   <= PERIOD_RESET[CNT_W-1:0];
        end else if (wr) begin
            if (address == 3'd0) data <= writedata[WIDTH-1:0];
            if (address == 3'd1) blink_en <= writedata[WIDTH-1:0];
            if (address == 3'd2) period <= writedata[CNT_W-1:0];
            if (address == 3'd4) data <= data | writedata[WIDTH-1:0];
            if (address == 3'd5) data <= data & ~writedata[WIDTH-1:0];
        end
    end

    // blink engine: half-period counter; a PERIOD write restarts it with phase on
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if ((wr && address == 3'd2) || period == '0) begin
            cnt   <= '0;
            phase <= 1'b1;
        end else if (cnt == period - CNT_W'(1)) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // read mux; write-only and unmapped addresses read as zero
    always_comb begin
        rd_mux = (address == 3'd0) ? 32'(data) :
                 (address == 3'd1) ? 32'(blink_en) :
                 (address == 3'd2) ? 32'(period) :
                 (address == 3'd3) ? 32'(phase) : 32'h0;
    end

    // registered read data and LED drive, updated every clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            out_port <= RESET_VALUE[WIDTH-1:0];
        end else begin
            readdata <= rd_mux;
            out_port <= data & (~blink_en | {WIDTH{phase}});
        end
    end
endmodule

// File: tb/tb_rlc_game_system_ledout_pio.sv
// tb_rlc_game_system_ledout_pio: vector table, directed blink/reset sequences and random run against a model
module tb_rlc_game_system_ledout_pio;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [9:0]  out_port;

    int checks = 0;
    int errors = 0;

    rlc_game_system_ledout_pio #(.RESET_VALUE(32'h155)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    always #5 clk = ~clk;

    logic [9:0]  m_data, m_blink, m_out;
    logic [31:0] m_rd;
    longint      m_period, m_t;

    typedef struct {
        logic [2:0]  a;
        logic        cs;
        logic        wn;
        logic [31:0] wd;
        logic [31:0] rd;
        logic [9:0]  out;
    } vec_t;
    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_phase();
        return (m_period == 0) || ((m_t / m_period) % 2 == 0);
    endfunction

    task automatic m_reset();
        m_data = 10'h155; m_blink = '0; m_period = 25000000; m_t = 0; m_rd = '0; m_out = 10'h155;
    endtask

    task automatic step(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] wd);
        logic ph;
        address = a; chipselect = cs; write_n = wn; writedata = wd;
        @(posedge clk);
        ph = m_phase();
        m_out = m_data & (~m_blink | {10{ph}});
        m_rd = (a == 0) ? 32'(m_data) : (a == 1) ? 32'(m_blink) :
               (a == 2) ? 32'(m_period) : (a == 3) ? 32'(ph) : 32'h0;
        m_t++;
        if (cs && !wn) begin
            if (a == 0) m_data = wd[9:0];
            if (a == 1) m_blink = wd[9:0];
            if (a == 2) begin m_period = longint'(wd[25:0]); m_t = 0; end
            if (a == 4) m_data = m_data | wd[9:0];
            if (a == 5) m_data = m_data & ~wd[9:0];
        end
        #1;
        chk("model_readdata", readdata, m_rd);
        chk("model_out_port", 32'(out_port), 32'(m_out));
    endtask

    initial begin
        int  v[40];
        int  last, ntog, b1_bad;
        bit  seen;
        tbl[0]  = '{3'd0, 1'b1, 1'b0, 32'h3FF,      32'h155,      10'h155};
        tbl[1]  = '{3'd5, 1'b1, 1'b0, 32'h00F,      32'h0,        10'h3FF};
        tbl[2]  = '{3'd4, 1'b1, 1'b0, 32'h001,      32'h0,        10'h3F0};
        tbl[3]  = '{3'd0, 1'b1, 1'b1, 32'h0,        32'h3F1,      10'h3F1};
        tbl[4]  = '{3'd4, 1'b1, 1'b1, 32'h0,        32'h0,        10'h3F1};
        tbl[5]  = '{3'd5, 1'b1, 1'b1, 32'h0,        32'h0,        10'h3F1};
        tbl[6]  = '{3'd0, 1'b0, 1'b0, 32'h0,        32'h3F1,      10'h3F1};
        tbl[7]  = '{3'd6, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,        10'h3F1};
        tbl[8]  = '{3'd7, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0,        10'h3F1};
        tbl[9]  = '{3'd0, 1'b1, 1'b1, 32'h0,        32'h3F1,      10'h3F1};
        tbl[10] = '{3'd1, 1'b1, 1'b1, 32'h0,        32'h0,        10'h3F1};
        tbl[11] = '{3'd3, 1'b1, 1'b1, 32'h0,        32'h1,        10'h3F1};
        tbl[12] = '{3'd2, 1'b1, 1'b1, 32'h0,        32'd25000000, 10'h3F1};
        tbl[13] = '{3'd0, 1'b1, 1'b0, 32'hFFFFF000, 32'h3F1,      10'h3F1};
        tbl[14] = '{3'd0, 1'b1, 1'b1, 32'h0,        32'h0,        10'h000};
        tbl[15] = '{3'd0, 1'b1, 1'b0, 32'h3F1,      32'h0,        10'h000};
        tbl[16] = '{3'd0, 1'b1, 1'b1, 32'h0,        32'h3F1,      10'h3F1};

        m_reset();
        #12;
        chk("reset_out_port", 32'(out_port), 32'h155);
        chk("reset_readdata", readdata, 32'h0);
        #10 reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            step(tbl[i].a, tbl[i].cs, tbl[i].wn, tbl[i].wd);
            chk($sformatf("vec%0d_readdata", i), readdata, tbl[i].rd);
            chk($sformatf("vec%0d_out_port", i), 32'(out_port), 32'(tbl[i].out));
        end

        step(3'd2, 1'b1, 1'b0, 32'd4);
        step(3'd1, 1'b1, 1'b0, 32'h001);
        step(3'd0, 1'b1, 1'b0, 32'h003);
        b1_bad = 0;
        for (int i = 0; i < 40; i++) begin
            step(3'd0, 1'b1, 1'b1, 32'h0);
            v[i] = int'(out_port[0]);
            if (out_port[1] !== 1'b1) b1_bad++;
        end
        last = -1; ntog = 0;
        for (int i = 1; i < 40; i++) begin
            if (v[i] != v[i-1]) begin
                if (last >= 0) chk("blink_interval", 32'(i - last), 32'd4);
                last = i; ntog++;
            end
        end
        chk("blink_toggles_seen", 32'(ntog >= 8), 32'd1);
        chk("steady_bit1_lows", 32'(b1_bad), 32'd0);

        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(3'd3, 1'b1, 1'b1, 32'h0);
            seen = (readdata == 32'h0);
        end
        chk("phase0_reached", 32'(seen), 32'd1);
        step(3'd2, 1'b1, 1'b0, 32'd0);
        step(3'd3, 1'b1, 1'b1, 32'h0);
        chk("frozen_phase_reads_1", readdata, 32'h1);
        b1_bad = 0;
        for (int i = 0; i < 16; i++) begin
            step(3'd3, 1'b1, 1'b1, 32'h0);
            if (out_port[0] !== 1'b1 || readdata !== 32'h1) b1_bad++;
        end
        chk("frozen_no_toggle", 32'(b1_bad), 32'd0);

        step(3'd2, 1'b1, 1'b0, 32'd4);
        step(3'd0, 1'b1, 1'b1, 32'h0);
        step(3'd0, 1'b1, 1'b1, 32'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_reset_out_port", 32'(out_port), 32'h155);
        chk("async_reset_readdata", readdata, 32'h0);
        m_reset();
        #3 reset_n = 1'b1;
        step(3'd2, 1'b1, 1'b1, 32'h0);
        chk("post_reset_period", readdata, 32'd25000000);
        step(3'd3, 1'b1, 1'b1, 32'h0);
        chk("post_reset_phase", readdata, 32'h1);
        step(3'd1, 1'b1, 1'b0, 32'h3FF);
        b1_bad = 0;
        for (int i = 0; i < 150; i++) begin
            step(3'd3, 1'b1, 1'b1, 32'h0);
            if (out_port !== 10'h155) b1_bad++;
        end
        chk("post_reset_no_early_toggle", 32'(b1_bad), 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd2) wd = $urandom_range(0, 6);
            step(a, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), wd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
